// File: rtl/img_ctrl_pkg.sv
// Shared command codes, FSM states and sizing constants for img_disp_ctrl.
// Codes 8/9 are only decoded when IMG_MIRROR_EN is defined.
package img_ctrl_pkg;

  localparam int IMG_W   = 8;
  localparam int PIX_W   = 8;
  localparam int NPIX    = IMG_W * IMG_W;
  localparam int ADDR_W  = $clog2(NPIX);
  localparam int COORD_W = $clog2(IMG_W);
  localparam int CMD_W   = 4;

  localparam logic [CMD_W-1:0] CMD_WRITE    = 4'd0;
  localparam logic [CMD_W-1:0] CMD_UP       = 4'd1;
  localparam logic [CMD_W-1:0] CMD_DOWN     = 4'd2;
  localparam logic [CMD_W-1:0] CMD_LEFT     = 4'd3;
  localparam logic [CMD_W-1:0] CMD_RIGHT    = 4'd4;
  localparam logic [CMD_W-1:0] CMD_MAX      = 4'd5;
  localparam logic [CMD_W-1:0] CMD_MIN      = 4'd6;
  localparam logic [CMD_W-1:0] CMD_AVG      = 4'd7;
  localparam logic [CMD_W-1:0] CMD_MIRROR_X = 4'd8;
  localparam logic [CMD_W-1:0] CMD_MIRROR_Y = 4'd9;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/img_win_alu.sv
// Combinational 2x2 window operator: max, min, floor-average and, when
// IMG_MIRROR_EN is defined, row/column mirroring. Pixel order is TL, TR, BL, BR.
module img_win_alu #(
  parameter int W = 8
) (
  input  logic [3:0]   op_i,
  input  logic [W-1:0] p0_i,
  input  logic [W-1:0] p1_i,
  input  logic [W-1:0] p2_i,
  input  logic [W-1:0] p3_i,
  output logic [W-1:0] n0_o,
  output logic [W-1:0] n1_o,
  output logic [W-1:0] n2_o,
  output logic [W-1:0] n3_o,
  output logic         we_o
);
  import img_ctrl_pkg::*;

  logic [W-1:0] maxA, maxB, maxAll;
  logic [W-1:0] minA, minB, minAll;
  logic [W+1:0] sum;

  // Two-level compare trees; the sum keeps two guard bits so it never wraps
  always_comb begin
    maxA   = (p0_i > p1_i) ? p0_i : p1_i;
    maxB   = (p2_i > p3_i) ? p2_i : p3_i;
    maxAll = (maxA > maxB) ? maxA : maxB;
    minA   = (p0_i < p1_i) ? p0_i : p1_i;
    minB   = (p2_i < p3_i) ? p2_i : p3_i;
    minAll = (minA < minB) ? minA : minB;
    sum    = {2'b00, p0_i} + {2'b00, p1_i} + {2'b00, p2_i} + {2'b00, p3_i};
  end

  always_comb begin
    n0_o = p0_i;
    n1_o = p1_i;
    n2_o = p2_i;
    n3_o = p3_i;
    we_o = 1'b0;
    case (op_i)
      CMD_MAX: begin
        {n0_o, n1_o, n2_o, n3_o} = {maxAll, maxAll, maxAll, maxAll};
        we_o = 1'b1;
      end
      CMD_MIN: begin
        {n0_o, n1_o, n2_o, n3_o} = {minAll, minAll, minAll, minAll};
        we_o = 1'b1;
      end
      CMD_AVG: begin
        {n0_o, n1_o, n2_o, n3_o} = {sum[W+1:2], sum[W+1:2], sum[W+1:2], sum[W+1:2]};
        we_o = 1'b1;
      end
`ifdef IMG_MIRROR_EN
      CMD_MIRROR_X: begin
        {n0_o, n1_o, n2_o, n3_o} = {p2_i, p3_i, p0_i, p1_i};
        we_o = 1'b1;
      end
      CMD_MIRROR_Y: begin
        {n0_o, n1_o, n2_o, n3_o} = {p1_i, p0_i, p3_i, p2_i};
        we_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/img_disp_ctrl.sv
// Image display controller: loads the image from IROM, applies host window
// commands, streams the buffer to IRAM. IMG_MIRROR_EN enables mirror commands.
module img_disp_ctrl #(
  parameter int IMG_W = 8,
  parameter int PIX_W = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     cmd,
  input  logic                           cmd_valid,
  input  logic [PIX_W-1:0]               IROM_Q,
  output logic                           IROM_EN,
  output logic [$clog2(IMG_W*IMG_W)-1:0] IROM_A,
  output logic                           IRAM_valid,
  output logic [PIX_W-1:0]               IRAM_D,
  output logic [$clog2(IMG_W*IMG_W)-1:0] IRAM_A,
  output logic                           busy,
  output logic                           done
);
  import img_ctrl_pkg::*;

  localparam int NPX = IMG_W * IMG_W;
  localparam int AW  = $clog2(NPX);
  localparam int CW  = $clog2(IMG_W);
  localparam logic [AW-1:0] LAST_A = AW'(NPX - 1);
  localparam logic [AW-1:0] A_ONE  = AW'(1);
  localparam logic [CW-1:0] XY_MIN = CW'(1);
  localparam logic [CW-1:0] XY_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] XY_RST = CW'(IMG_W / 2);

  state_e           state_q, state_d;
  logic             romEn_q, romEn_d;
  logic [AW-1:0]    romA_q, romA_d;
  logic             addrDone_q, addrDone_d;
  logic             capValid_q, capValid_d;
  logic [AW-1:0]    capIdx_q, capIdx_d;
  logic [CW-1:0]    x_q, x_d, y_q, y_d;
  logic [3:0]       op_q, op_d;
  logic             iramValid_q, iramValid_d;
  logic [PIX_W-1:0] iramD_q, iramD_d;
  logic [AW-1:0]    iramA_q, iramA_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PIX_W-1:0] buf_q [NPX];

  logic [CW-1:0]    xm1, ym1;
  logic [AW-1:0]    idx0, idx1, idx2, idx3, nextA;
  logic [PIX_W-1:0] new0, new1, new2, new3;
  logic             aluWe;

  // Pixel index row*IMG_W+col is a plain concatenation for a power-of-two width
  assign xm1   = x_q - XY_MIN;
  assign ym1   = y_q - XY_MIN;
  assign idx0  = {ym1, xm1};
  assign idx1  = {ym1, x_q};
  assign idx2  = {y_q, xm1};
  assign idx3  = {y_q, x_q};
  assign nextA = iramA_q + A_ONE;

  img_win_alu #(.W(PIX_W)) u_alu (
    .op_i (op_q),
    .p0_i (buf_q[idx0]),
    .p1_i (buf_q[idx1]),
    .p2_i (buf_q[idx2]),
    .p3_i (buf_q[idx3]),
    .n0_o (new0),
    .n1_o (new1),
    .n2_o (new2),
    .n3_o (new3),
    .we_o (aluWe)
  );

  always_comb begin
    state_d     = state_q;
    romEn_d     = romEn_q;
    romA_d      = romA_q;
    addrDone_d  = addrDone_q;
    capValid_d  = 1'b0;
    capIdx_d    = capIdx_q;
    x_d         = x_q;
    y_d         = y_q;
    op_d        = op_q;
    iramValid_d = iramValid_q;
    iramD_d     = iramD_q;
    iramA_d     = iramA_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      // ROM samples romA_q on every edge with romEn_q low; its data is captured one edge later
      ST_LOAD: begin
        busy_d = 1'b1;
        if (!romEn_q) begin
          capValid_d = 1'b1;
          capIdx_d   = romA_q;
          if (romA_q == LAST_A) begin
            romEn_d    = 1'b1;
            addrDone_d = 1'b1;
          end else begin
            romA_d = romA_q + A_ONE;
          end
        end else if (!addrDone_q) begin
          romEn_d = 1'b0;
          romA_d  = '0;
        end
        if (capValid_q && capIdx_q == LAST_A) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          busy_d = 1'b1;
          op_d   = cmd;
          if (cmd == CMD_WRITE) begin
            state_d     = ST_WRITE;
            iramValid_d = 1'b1;
            iramA_d     = '0;
            iramD_d     = buf_q[0];
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        case (op_q)
          CMD_UP:    if (y_q > XY_MIN) y_d = y_q - XY_MIN;
          CMD_DOWN:  if (y_q < XY_MAX) y_d = y_q + XY_MIN;
          CMD_LEFT:  if (x_q > XY_MIN) x_d = x_q - XY_MIN;
          CMD_RIGHT: if (x_q < XY_MAX) x_d = x_q + XY_MIN;
          default: ;
        endcase
      end
      ST_WRITE: begin
        if (iramA_q == LAST_A) begin
          iramValid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else begin
          iramA_d = nextA;
          iramD_d = buf_q[nextA];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      romEn_q     <= 1'b1;
      romA_q      <= '0;
      addrDone_q  <= 1'b0;
      capValid_q  <= 1'b0;
      capIdx_q    <= '0;
      x_q         <= XY_RST;
      y_q         <= XY_RST;
      op_q        <= '0;
      iramValid_q <= 1'b0;
      iramD_q     <= '0;
      iramA_q     <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      romEn_q     <= romEn_d;
      romA_q      <= romA_d;
      addrDone_q  <= addrDone_d;
      capValid_q  <= capValid_d;
      capIdx_q    <= capIdx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      op_q        <= op_d;
      iramValid_q <= iramValid_d;
      iramD_q     <= iramD_d;
      iramA_q     <= iramA_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Image buffer has no reset: it is always fully reloaded before use
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && capValid_q) begin
      buf_q[capIdx_q] <= IROM_Q;
    end else if (state_q == ST_EXEC && aluWe) begin
      buf_q[idx0] <= new0;
      buf_q[idx1] <= new1;
      buf_q[idx2] <= new2;
      buf_q[idx3] <= new3;
    end
  end

  assign IROM_EN    = romEn_q;
  assign IROM_A     = romA_q;
  assign IRAM_valid = iramValid_q;
  assign IRAM_D     = iramD_q;
  assign IRAM_A     = iramA_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
